// File: rtl/bip_pkg.sv
// Shared constants for the BIP-style processor: widths, datapath select codes, opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bip_pkg;

    localparam int B_DEF = 16;
    localparam int W_DEF = 11;

    // Accumulator source select
    localparam logic [1:0] SELA_MEM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    // ALU B-operand source select
    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    // ALU operation
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Instruction opcodes decoded by control
    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;

endpackage

// File: rtl/data_memory.sv
// 2^W x B data memory, synchronous write, asynchronous read gated by re (0 when idle).
// Latency: write visible one edge later; read is combinational.
// Backpressure: none; one access per cycle, always accepted.
module data_memory
    import bip_pkg::*;
#(
    parameter int B = B_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] addr,
    input  logic [B-1:0] din,
    input  logic         re,
    output logic [B-1:0] dout
);

    logic [B-1:0] mem [2**W];

    // Write port: contents are deliberately not reset and survive a core reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // Read port: disabled reads return 0 so undriven reads are deterministic
    always_comb begin
        dout = re ? mem[addr] : '0;
    end

endmodule

// File: rtl/datapath.sv
// Accumulator datapath: accumulator, add/sub ALU, immediate sign-extender, sticky overflow, data memory.
// Latency: control to Acc/Ovf 1 edge; Addr/RdRam to DataOut combinational.
// Backpressure: none; one control word per cycle, always consumed.
module datapath
    import bip_pkg::*;
#(
    parameter int B = B_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   SelA,
    input  logic         SelB,
    input  logic         WrAcc,
    input  logic         Op,
    input  logic         WrRam,
    input  logic         RdRam,
    input  logic [W-1:0] Operand,
    input  logic [W-1:0] Addr,
    output logic [B-1:0] Acc,
    output logic         Ovf,
    output logic [B-1:0] DataOut
);

    logic [B-1:0] acc_q, acc_d;
    logic         ovf_q, ovf_d;
    logic [B-1:0] ext;
    logic [B-1:0] mem_rd;
    logic [B-1:0] b_in;
    logic [B-1:0] res;
    logic         ovf_now;
    logic         mem_we;

    // Writes are suppressed while reset is held; memory always stores the pre-edge accumulator
    assign mem_we = WrRam & ~reset;

    data_memory #(
        .B(B),
        .W(W)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (Addr),
        .din  (acc_q),
        .re   (RdRam),
        .dout (mem_rd)
    );

    // Sign-extend the immediate, run the ALU and detect signed overflow of this cycle's result
    always_comb begin
        ext  = {{(B-W){Operand[W-1]}}, Operand};
        b_in = (SelB == SELB_IMM) ? ext : mem_rd;
        res  = (Op == OP_SUB) ? (acc_q - b_in) : (acc_q + b_in);
        // add overflows on equal operand signs, sub on differing ones; either way the result sign flips vs Acc
        ovf_now = ((acc_q[B-1] ^ b_in[B-1]) == (Op == OP_SUB)) && (res[B-1] ^ acc_q[B-1]);
    end

    // Next accumulator / overflow state; reserved SelA code holds the accumulator
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (WrAcc) begin
            case (SelA)
                SELA_MEM: acc_d = mem_rd;
                SELA_IMM: acc_d = ext;
                SELA_ALU: begin
                    acc_d = res;
                    ovf_d = ovf_q | ovf_now;
                end
                default:  acc_d = acc_q;
            endcase
        end
    end

    // Accumulator and sticky overflow registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign Acc     = acc_q;
    assign Ovf     = ovf_q;
    assign DataOut = mem_rd;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath: vector table plus hand-written multi-cycle sequences.
// Latency: checks Acc/Ovf 1 edge after each control word, DataOut before the edge.
// Backpressure: n/a.
module tb_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  SelA = 2'b00;
    logic        SelB = 1'b0;
    logic        WrAcc = 1'b0;
    logic        Op = 1'b0;
    logic        WrRam = 1'b0;
    logic        RdRam = 1'b0;
    logic [10:0] Operand = '0;
    logic [10:0] Addr = '0;
    logic [15:0] Acc;
    logic        Ovf;
    logic [15:0] DataOut;

    int n_tests = 0;
    int n_fail  = 0;

    datapath dut (
        .clk     (clk),
        .reset   (reset),
        .SelA    (SelA),
        .SelB    (SelB),
        .WrAcc   (WrAcc),
        .Op      (Op),
        .WrRam   (WrRam),
        .RdRam   (RdRam),
        .Operand (Operand),
        .Addr    (Addr),
        .Acc     (Acc),
        .Ovf     (Ovf),
        .DataOut (DataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sela;
        logic        selb;
        logic        wracc;
        logic        op;
        logic        wrram;
        logic        rdram;
        logic [10:0] operand;
        logic [10:0] addr;
        logic [15:0] exp_dout;
        logic [15:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [1:0] sa, input logic sb, input logic wa,
                                input logic op, input logic wr, input logic rd,
                                input logic [10:0] opd, input logic [10:0] ad,
                                input logic [15:0] edout, input logic [15:0] eacc,
                                input logic eovf);
        vec_t v;
        v.sela = sa; v.selb = sb; v.wracc = wa; v.op = op; v.wrram = wr; v.rdram = rd;
        v.operand = opd; v.addr = ad; v.exp_dout = edout; v.exp_acc = eacc; v.exp_ovf = eovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sa, input logic sb, input logic wa, input logic op,
                         input logic wr, input logic rd, input logic [10:0] opd,
                         input logic [10:0] ad);
        SelA = sa; SelB = sb; WrAcc = wa; Op = op; WrRam = wr; RdRam = rd;
        Operand = opd; Addr = ad;
    endtask

    // One instruction: drive, take one edge, settle 1 time unit past it
    task automatic cyc(input logic [1:0] sa, input logic sb, input logic wa, input logic op,
                       input logic wr, input logic rd, input logic [10:0] opd,
                       input logic [10:0] ad);
        drive(sa, sb, wa, op, wr, rd, opd, ad);
        @(posedge clk);
        #1;
    endtask

    task automatic ldi(input logic [10:0] v);      cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v, 11'h0); endtask
    task automatic sto(input logic [10:0] a);      cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h0, a); endtask
    task automatic add_mem(input logic [10:0] a);  cyc(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h0, a); endtask
    task automatic addi(input logic [10:0] v);     cyc(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v, 11'h0); endtask
    task automatic subi(input logic [10:0] v);     cyc(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, v, 11'h0); endtask
    task automatic idle();                         drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 11'h0); endtask

    // Acc := 2*Acc via a scratch word
    task automatic dbl(input logic [10:0] a);
        sto(a);
        add_mem(a);
    endtask

    initial begin
        //              SelA   SelB  WrAcc Op    WrRam RdRam Operand  Addr     DataOut   Acc       Ovf
        vecs[0]  = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h005, 11'h000, 16'h0000, 16'h0005, 1'b0); // LDI 5
        vecs[1]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 11'h010, 16'h0000, 16'h0005, 1'b0); // STO 0x010
        vecs[2]  = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 11'h000, 16'h0000, 16'h0000, 1'b0); // LDI 0
        vecs[3]  = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000, 11'h010, 16'h0005, 16'h0005, 1'b0); // LD 0x010
        vecs[4]  = mk(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF, 11'h000, 16'h0000, 16'h0004, 1'b0); // ADDI -1
        vecs[5]  = mk(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h004, 11'h000, 16'h0000, 16'h0000, 1'b0); // SUBI 4
        vecs[6]  = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h003, 11'h000, 16'h0000, 16'h0003, 1'b0); // LDI 3
        vecs[7]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 11'h020, 16'h0000, 16'h0003, 1'b0); // STO 0x020
        vecs[8]  = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h00A, 11'h000, 16'h0000, 16'h000A, 1'b0); // LDI 10
        vecs[9]  = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h000, 11'h020, 16'h0003, 16'h0007, 1'b0); // SUB+STO collide
        vecs[10] = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000, 11'h020, 16'h000A, 16'h000A, 1'b0); // LD 0x020
        vecs[11] = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h3FF, 11'h000, 16'h0000, 16'h03FF, 1'b0); // LDI max pos
        vecs[12] = mk(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h3FF, 11'h000, 16'h0000, 16'h07FE, 1'b0); // ADDI 0x3FF
        vecs[13] = mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h123, 11'h000, 16'h0000, 16'h07FE, 1'b0); // SelA reserved
        vecs[14] = mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000, 11'h020, 16'h000A, 16'h0808, 1'b0); // ADD mem
        vecs[15] = mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 11'h020, 16'h0000, 16'h0808, 1'b0); // ADD, RdRam=0
        vecs[16] = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 11'h020, 16'h0000, 16'h0000, 1'b0); // LD, RdRam=0

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_acc", Acc, 16'h0000);
        check("reset_ovf", {15'h0, Ovf}, 16'h0000);
        reset = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].sela, vecs[i].selb, vecs[i].wracc, vecs[i].op,
                  vecs[i].wrram, vecs[i].rdram, vecs[i].operand, vecs[i].addr);
            #1;
            check($sformatf("v%0d_dout", i), DataOut, vecs[i].exp_dout);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_acc", i), Acc, vecs[i].exp_acc);
            check($sformatf("v%0d_ovf", i), {15'h0, Ovf}, {15'h0, vecs[i].exp_ovf});
        end

        // Collision wrote the old Acc (10) into 0x020
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h0, 11'h020);
        #1;
        check("collide_mem", DataOut, 16'h000A);

        // Build 0x7FFF without overflow, then ADDI 1 overflows
        ldi(11'h200);
        for (int k = 0; k < 5; k++) dbl(11'h100);
        check("build_4000", Acc, 16'h4000);
        check("build_ovf0", {15'h0, Ovf}, 16'h0000);
        sto(11'h101);
        subi(11'h001);
        add_mem(11'h101);
        check("build_7fff", Acc, 16'h7FFF);
        check("no_ovf_7fff", {15'h0, Ovf}, 16'h0000);
        addi(11'h001);
        check("addi_ovf_acc", Acc, 16'h8000);
        check("addi_ovf", {15'h0, Ovf}, 16'h0001);
        ldi(11'h000);
        check("sticky_acc", Acc, 16'h0000);
        check("sticky_ovf", {15'h0, Ovf}, 16'h0001);

        // Mid-cycle reset clears immediately; writes blocked while held
        ldi(11'h005);
        check("pre_rst_acc", Acc, 16'h0005);
        idle();
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_acc", Acc, 16'h0000);
        check("async_rst_ovf", {15'h0, Ovf}, 16'h0000);
        drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h055, 11'h010);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_acc", Acc, 16'h0000);
        reset = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h0, 11'h010);
        #1;
        check("rst_no_write", DataOut, 16'h0005);

        // Negative build to 0x8000, SUBI 1 overflows
        ldi(11'h400);
        check("ldi_neg", Acc, 16'hFC00);
        for (int k = 0; k < 5; k++) dbl(11'h102);
        check("build_8000", Acc, 16'h8000);
        check("build_ovf_neg", {15'h0, Ovf}, 16'h0000);
        subi(11'h001);
        check("subi_ovf_acc", Acc, 16'h7FFF);
        check("subi_ovf", {15'h0, Ovf}, 16'h0001);

        // WrAcc=0 with everything else toggling: Acc holds
        ldi(11'h123);
        for (int k = 0; k < 4; k++) begin
            cyc(2'($urandom_range(0, 3)), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom),
                1'($urandom), 11'($urandom), 11'h300 + 11'($urandom_range(0, 255)));
            check($sformatf("hold%0d_acc", k), Acc, 16'h0123);
            check($sformatf("hold%0d_ovf", k), {15'h0, Ovf}, 16'h0001);
        end

        // All enables low: memory word untouched
        idle();
        @(posedge clk);
        #1;
        RdRam = 1'b1;
        Addr  = 11'h020;
        #1;
        check("hlt_mem", DataOut, 16'h000A);
        check("hlt_acc", Acc, 16'h0123);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
